lcd_bus_responder: RTL and testbench
====================================

Name: lcd_bus_responder

Overview:
- LCD-side end of the display command interface (DATA/OPER/ENB in, RDY out).
- Accepts one-byte commands from the upstream sender and drives an HD44780-compatible 8-bit parallel LCD bus (RS/RW/E/DB).
- Enforces bus setup, enable-pulse and hold timing, plus the post-command execution delay.
- Runs the power-on initialisation sequence autonomously; RDY tells the sender when the next command may be issued.

Parameters:
T_SETUP, 2, clk cycles RS/DB stable before E rises (>= 1)
T_EPW, 12, clk cycles E held high (>= 1)
T_HOLD, 2, clk cycles RS/DB held after E falls (>= 1)
T_CMD_WAIT, 2000, execution wait after a normal data/instruction write
T_CLR_WAIT, 82000, execution wait after clear (0x01) or return-home (0x02/0x03)
T_POWERUP, 750000, wait after reset before first init write
- Counter width is $clog2 of the largest parameter plus 1.

Ports:
clk  input  1  system clock, all logic rising-edge
rst_n  input  1  asynchronous active-low reset
DATA  input  8  command byte (character code or instruction)
OPER  input  2  00 = write character (RS=1); 01 = write instruction (RS=0); 10 = clear display (DATA ignored, sends 0x01); 11 = re-run init sequence
ENB  input  1  command strobe, sampled on clk when RDY=1
RDY  output  1  high when a command can be accepted
LCD_RS  output  1  register select
LCD_RW  output  1  read/write, always 0 (write only)
LCD_E  output  1  enable strobe
LCD_DB  output  8  data bus

Behaviour:
- Reset (async assert, sync release):
  - State PWR_WAIT; counter = 0.
  - RDY = 0, LCD_E = 0, LCD_RS = 0, LCD_RW = 0, LCD_DB = 8'h00.
  - Reset asserted mid-transfer drops LCD_E in the same instant.
- States: PWR_WAIT, INIT_LOAD, SETUP, E_HIGH, HOLD, EXEC_WAIT, IDLE.
- PWR_WAIT: count T_POWERUP cycles, then INIT_LOAD with init index = 0.
- INIT_LOAD:
  - Load ROM[index] with RS=0. ROM = 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 (6 entries).
  - Go to SETUP.
- SETUP: DB/RS driven, E = 0, for T_SETUP cycles -> E_HIGH.
- E_HIGH: E = 1 for exactly T_EPW cycles -> HOLD.
- HOLD: E = 0, DB/RS unchanged, for T_HOLD cycles -> EXEC_WAIT.
- EXEC_WAIT:
  - Wait T_CLR_WAIT if the RS=0 byte sent was 0x01, 0x02 or 0x03; otherwise T_CMD_WAIT.
  - Then: if in init and index < 5, increment index -> INIT_LOAD; if in init and index = 5, clear the init flag -> IDLE; if not in init -> IDLE.
- IDLE:
  - RDY = 1. DB/RS keep the last driven values.
  - On ENB = 1: latch DATA/OPER into the command register and drop RDY on the next edge.
  - OPER 00/01/10 -> SETUP. OPER 11 -> set the init flag, index = 0, go to INIT_LOAD (no power-up wait).
- RDY is registered and high only in IDLE. First command accepted -> RDY low the following cycle.
- Latency, ENB edge to E rise: 1 + T_SETUP cycles.
- Total busy per command: T_SETUP + T_EPW + T_HOLD + wait cycles, then 1 cycle to IDLE.
- ENB while RDY = 0 is ignored (dropped), except as described under Optional Feature.
- ENB held high for multiple cycles in IDLE is treated as one command per acceptance. No edge detection: a held ENB retriggers once RDY returns.
- Counter reset to 0 on every state entry. No wrap; the terminal compare is equality with (param - 1).

Optional Feature:
- Macro: LCD_CMD_SKID_EN.
- Defined:
  - One-entry skid register; RDY = 1 whenever the skid is empty (including while busy).
  - ENB while busy loads the skid. On entering IDLE with the skid full, the skid command is launched the same cycle (IDLE lasts 1 cycle) and the skid is cleared.
  - ENB in the same cycle as a skid launch is stored into the skid.
  - OPER 11 in the skid flushes nothing else.
- Undefined: RDY only in IDLE, and busy-time ENB is dropped.

Test Plan:
- Bench parameters: T_SETUP=2, T_EPW=4, T_HOLD=2, T_CMD_WAIT=10, T_CLR_WAIT=30, T_POWERUP=50.
- Release rst_n -> RDY stays 0; after 50 cycles, 6 E pulses each 4 cycles wide, DB = 38, 38, 38, 0C, 01, 06, RS = 0. The gap after 0x01 is 30 cycles, the others 10. RDY = 1 afterwards.
- In IDLE, ENB with OPER=00, DATA=0x41 -> RDY low the next cycle; E rises 3 cycles after ENB with RS=1, DB=0x41; RDY returns after 2+4+2+10+1 cycles.
- OPER=10 -> DB=0x01, RS=0, wait 30 cycles; OPER=01 with DATA=0x80 -> RS=0, wait 10 cycles.
- ENB pulsed during busy (macro undefined) -> no extra E pulse. Macro defined -> second command's E rises immediately after the first command's wait.
- Assert rst_n during E_HIGH -> LCD_E = 0 asynchronously, RDY = 0; full init repeats after release.
- OPER=11 in IDLE -> 6-write init sequence without the 50-cycle power-up wait, then RDY = 1.

Source files
------------

// File: rtl/lcd_bus_responder_if.sv
// Command link (DATA/OPER/ENB/RDY) and HD44780 8-bit parallel bus between
// the upstream sender and the LCD bus responder.
interface lcd_bus_responder_if;
  logic [7:0] DATA;
  logic [1:0] OPER;
  logic       ENB;
  logic       RDY;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       LCD_E;
  logic [7:0] LCD_DB;

  modport master (
    output DATA, OPER, ENB,
    input  RDY, LCD_RS, LCD_RW, LCD_E, LCD_DB
  );

  modport slave (
    input  DATA, OPER, ENB,
    output RDY, LCD_RS, LCD_RW, LCD_E, LCD_DB
  );
endinterface

// File: rtl/lcd_bus_responder.sv
// LCD-side responder: runs HD44780 power-on init, then turns one-byte commands
// into timed RS/DB/E writes. Optional one-entry command skid: LCD_CMD_SKID_EN.
module lcd_bus_responder #(
  parameter int unsigned T_SETUP    = 2,
  parameter int unsigned T_EPW      = 12,
  parameter int unsigned T_HOLD     = 2,
  parameter int unsigned T_CMD_WAIT = 2000,
  parameter int unsigned T_CLR_WAIT = 82000,
  parameter int unsigned T_POWERUP  = 750000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lcd_bus_responder_if.slave   bus
);

  localparam int unsigned T_MAX_A  = (T_SETUP > T_EPW) ? T_SETUP : T_EPW;
  localparam int unsigned T_MAX_B  = (T_MAX_A > T_HOLD) ? T_MAX_A : T_HOLD;
  localparam int unsigned T_MAX_C  = (T_MAX_B > T_CMD_WAIT) ? T_MAX_B : T_CMD_WAIT;
  localparam int unsigned T_MAX_D  = (T_MAX_C > T_CLR_WAIT) ? T_MAX_C : T_CLR_WAIT;
  localparam int unsigned T_MAX    = (T_MAX_D > T_POWERUP) ? T_MAX_D : T_POWERUP;
  localparam int unsigned CNT_W    = $clog2(T_MAX) + 1;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned ROM_LAST = 5;

  typedef enum logic [2:0] {
    PWR_WAIT, INIT_LOAD, SETUP, E_HIGH, HOLD, EXEC_WAIT, IDLE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             init_q, init_d;
  logic             rdy_q, rdy_d;
  logic             e_q, e_d;
  logic             rs_q, rs_d;
  logic [7:0]       db_q, db_d;

  logic             go;
  logic [1:0]       go_oper;
  logic [7:0]       go_data;
  logic             long_wait;
  logic [CNT_W-1:0] wait_last;

`ifdef LCD_CMD_SKID_EN
  logic             skid_vld_q, skid_vld_d;
  logic [1:0]       skid_oper_q, skid_oper_d;
  logic [7:0]       skid_data_q, skid_data_d;
`endif

  function automatic logic [7:0] init_rom(input logic [IDX_W-1:0] i);
    logic [7:0] b;
    case (i)
      3'd0, 3'd1, 3'd2: b = 8'h38;
      3'd3:             b = 8'h0C;
      3'd4:             b = 8'h01;
      default:          b = 8'h06;
    endcase
    return b;
  endfunction

  // Clear and return-home need the long execution time.
  assign long_wait = !rs_q && ((db_q == 8'h01) || (db_q == 8'h02) || (db_q == 8'h03));
  assign wait_last = long_wait ? CNT_W'(T_CLR_WAIT - 1) : CNT_W'(T_CMD_WAIT - 1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    init_d  = init_q;
    rs_d    = rs_q;
    db_d    = db_q;
    go      = 1'b0;
    go_oper = bus.OPER;
    go_data = bus.DATA;
`ifdef LCD_CMD_SKID_EN
    skid_vld_d  = skid_vld_q;
    skid_oper_d = skid_oper_q;
    skid_data_d = skid_data_q;
    if (state_q != IDLE && bus.ENB && rdy_q) begin
      skid_vld_d  = 1'b1;
      skid_oper_d = bus.OPER;
      skid_data_d = bus.DATA;
    end
`endif

    case (state_q)
      PWR_WAIT: begin
        if (cnt_q == CNT_W'(T_POWERUP - 1)) begin
          state_d = INIT_LOAD;
          idx_d   = '0;
        end
      end
      INIT_LOAD: begin
        db_d    = init_rom(idx_q);
        rs_d    = 1'b0;
        state_d = SETUP;
      end
      SETUP: begin
        if (cnt_q == CNT_W'(T_SETUP - 1)) state_d = E_HIGH;
      end
      E_HIGH: begin
        if (cnt_q == CNT_W'(T_EPW - 1)) state_d = HOLD;
      end
      HOLD: begin
        if (cnt_q == CNT_W'(T_HOLD - 1)) state_d = EXEC_WAIT;
      end
      EXEC_WAIT: begin
        if (cnt_q == wait_last) begin
          if (init_q && idx_q != IDX_W'(ROM_LAST)) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = INIT_LOAD;
          end else begin
            init_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      IDLE: begin
`ifdef LCD_CMD_SKID_EN
        // A parked command leaves first; a new strobe this cycle takes its slot.
        if (skid_vld_q) begin
          go          = 1'b1;
          go_oper     = skid_oper_q;
          go_data     = skid_data_q;
          skid_vld_d  = bus.ENB && rdy_q;
          skid_oper_d = bus.OPER;
          skid_data_d = bus.DATA;
        end else if (bus.ENB && rdy_q) begin
          go = 1'b1;
        end
`else
        if (bus.ENB && rdy_q) go = 1'b1;
`endif
      end
      default: state_d = PWR_WAIT;
    endcase

    // Command launch from IDLE.
    if (go) begin
      case (go_oper)
        2'b00: begin rs_d = 1'b1; db_d = go_data; state_d = SETUP; end
        2'b01: begin rs_d = 1'b0; db_d = go_data; state_d = SETUP; end
        2'b10: begin rs_d = 1'b0; db_d = 8'h01;   state_d = SETUP; end
        default: begin
          init_d  = 1'b1;
          idx_d   = '0;
          state_d = INIT_LOAD;
        end
      endcase
    end

    cnt_d = (state_d != state_q || state_d == IDLE) ? '0 : cnt_q + CNT_W'(1);
    e_d   = (state_d == E_HIGH);
`ifdef LCD_CMD_SKID_EN
    rdy_d = !skid_vld_d || (state_d == IDLE);
`else
    rdy_d = (state_d == IDLE);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PWR_WAIT;
      cnt_q   <= '0;
      idx_q   <= '0;
      init_q  <= 1'b1;
      rdy_q   <= 1'b0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      db_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      init_q  <= init_d;
      rdy_q   <= rdy_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      db_q    <= db_d;
    end
  end

`ifdef LCD_CMD_SKID_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_vld_q  <= 1'b0;
      skid_oper_q <= 2'b00;
      skid_data_q <= 8'h00;
    end else begin
      skid_vld_q  <= skid_vld_d;
      skid_oper_q <= skid_oper_d;
      skid_data_q <= skid_data_d;
    end
  end
`endif

  assign bus.RDY    = rdy_q;
  assign bus.LCD_E  = e_q;
  assign bus.LCD_RS = rs_q;
  assign bus.LCD_DB = db_q;
  assign bus.LCD_RW = 1'b0;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed plus randomized bench for lcd_bus_responder (default build, no skid):
// E-pulse timing, RS/DB values and RDY turnaround checked against a timing model.
module tb_lcd_bus_responder;

  localparam int unsigned T_SETUP    = 2;
  localparam int unsigned T_EPW      = 4;
  localparam int unsigned T_HOLD     = 2;
  localparam int unsigned T_CMD_WAIT = 10;
  localparam int unsigned T_CLR_WAIT = 30;
  localparam int unsigned T_POWERUP  = 50;

  logic clk = 1'b0;
  logic rst_n;
  lcd_bus_responder_if bus();

  lcd_bus_responder #(
    .T_SETUP(T_SETUP), .T_EPW(T_EPW), .T_HOLD(T_HOLD),
    .T_CMD_WAIT(T_CMD_WAIT), .T_CLR_WAIT(T_CLR_WAIT), .T_POWERUP(T_POWERUP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail   = 0;
  int         rise_t[8];
  int         width_t[8];
  logic [7:0] db_t[8];
  logic       rs_t[8];
  int         npulse, rdy_at, stable_err, rw_err;
  logic [7:0] db_end;
  logic       rs_end;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Execution wait the LCD needs after the given write.
  function automatic int wait_of(input logic rs, input logic [7:0] db);
    if (!rs && db >= 8'h01 && db <= 8'h03) return int'(T_CLR_WAIT);
    return int'(T_CMD_WAIT);
  endfunction

  // Watch the bus one negedge at a time until RDY is seen high.
  task automatic observe(input int bound, input int drop_at, input int pulse_at);
    logic e_prev;
    npulse = 0; rdy_at = -1; stable_err = 0; rw_err = 0;
    e_prev = bus.LCD_E;
    for (int n = 1; n <= bound; n++) begin
      @(negedge clk);
      if (bus.LCD_E && !e_prev) begin
        if (npulse < 8) begin
          rise_t[npulse]  = n;
          db_t[npulse]    = bus.LCD_DB;
          rs_t[npulse]    = bus.LCD_RS;
          width_t[npulse] = 0;
        end
        npulse++;
      end
      if (bus.LCD_E && npulse > 0 && npulse <= 8) begin
        width_t[npulse-1]++;
        if (bus.LCD_DB !== db_t[npulse-1] || bus.LCD_RS !== rs_t[npulse-1]) stable_err++;
      end
      if (bus.LCD_RW !== 1'b0) rw_err++;
      e_prev = bus.LCD_E;
      if (n == drop_at) bus.ENB = 1'b0;
      if (pulse_at > 0 && n == pulse_at) bus.ENB = 1'b1;
      if (pulse_at > 0 && n == pulse_at + 1) bus.ENB = 1'b0;
      if (bus.RDY === 1'b1) begin
        rdy_at = n;
        db_end = bus.LCD_DB;
        rs_end = bus.LCD_RS;
        break;
      end
    end
  endtask

  task automatic check_cmd(input string tag, input logic [1:0] oper, input logic [7:0] data);
    logic       exp_rs;
    logic [7:0] exp_db;
    int         w;
    exp_rs = (oper == 2'b00);
    exp_db = (oper == 2'b10) ? 8'h01 : data;
    w      = wait_of(exp_rs, exp_db);
    chk({tag, "_pulses"}, npulse, 1);
    chk({tag, "_rise"},   rise_t[0], 1 + T_SETUP);
    chk({tag, "_width"},  width_t[0], T_EPW);
    chk({tag, "_rs"},     rs_t[0], exp_rs);
    chk({tag, "_db"},     db_t[0], exp_db);
    chk({tag, "_rdy"},    rdy_at, T_SETUP + T_EPW + T_HOLD + w + 1);
    chk({tag, "_hold"},   {rs_end, db_end}, {exp_rs, exp_db});
    chk({tag, "_stable"}, stable_err + rw_err, 0);
  endtask

  // Six ROM writes; first E rise 'start' cycles plus one load and setup after kick-off.
  task automatic check_init(input string tag, input int start);
    logic [7:0] rom[6];
    int         exp_rise;
    rom = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    exp_rise = start + 1 + T_SETUP;
    chk({tag, "_pulses"}, npulse, 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("%s_rise%0d", tag, i),  rise_t[i], exp_rise);
      chk($sformatf("%s_db%0d", tag, i),    db_t[i], rom[i]);
      chk($sformatf("%s_rs%0d", tag, i),    rs_t[i], 1'b0);
      chk($sformatf("%s_width%0d", tag, i), width_t[i], T_EPW);
      exp_rise += T_EPW + T_HOLD + wait_of(1'b0, rom[i]) + 1 + T_SETUP;
    end
    chk({tag, "_rdy"}, rdy_at, exp_rise - 1 - T_SETUP);
    chk({tag, "_stable"}, stable_err + rw_err, 0);
  endtask

  task automatic send(input string tag, input logic [1:0] oper, input logic [7:0] data);
    bus.ENB = 1'b1; bus.OPER = oper; bus.DATA = data;
    observe(400, 1, 0);
    check_cmd(tag, oper, data);
  endtask

  initial begin
    logic [1:0] oper;
    logic [7:0] data;
    int         bad;
    logic       found;

    rst_n = 1'b0;
    bus.ENB = 1'b0; bus.OPER = 2'b00; bus.DATA = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_rdy", bus.RDY, 1'b0);
    chk("rst_e",   bus.LCD_E, 1'b0);
    chk("rst_rs",  bus.LCD_RS, 1'b0);
    chk("rst_rw",  bus.LCD_RW, 1'b0);
    chk("rst_db",  bus.LCD_DB, 8'h00);

    rst_n = 1'b1;
    observe(1500, 0, 0);
    check_init("por", T_POWERUP);

    send("char41", 2'b00, 8'h41);
    send("clear",  2'b10, 8'hA5);
    send("ddram",  2'b01, 8'h80);
    send("home2",  2'b01, 8'h02);
    send("home3",  2'b01, 8'h03);
    send("ins04",  2'b01, 8'h04);
    send("ins00",  2'b01, 8'h00);

    for (int k = 0; k < 8; k++) begin
      oper = 2'($urandom_range(0, 2));
      data = 8'($urandom);
      send($sformatf("rnd%0d", k), oper, data);
    end

    // Strobe while busy must be dropped.
    bus.ENB = 1'b1; bus.OPER = 2'b00; bus.DATA = 8'h61;
    bus.ENB = 1'b1;
    observe(400, 1, 5);
    check_cmd("busy", 2'b00, 8'h61);
    bad = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (bus.LCD_E !== 1'b0 || bus.RDY !== 1'b1) bad++;
    end
    chk("busy_quiet", bad, 0);

    // Held strobe retriggers once RDY returns.
    bus.ENB = 1'b1; bus.OPER = 2'b00; bus.DATA = 8'h55;
    observe(400, 0, 0);
    check_cmd("held_a", 2'b00, 8'h55);
    observe(400, 1, 0);
    check_cmd("held_b", 2'b00, 8'h55);

    bus.ENB = 1'b1; bus.OPER = 2'b11; bus.DATA = 8'hFF;
    observe(1500, 1, 0);
    check_init("reinit", 1);

    // Reset during the E pulse.
    bus.ENB = 1'b1; bus.OPER = 2'b00; bus.DATA = 8'h5A;
    found = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) bus.ENB = 1'b0;
      if (bus.LCD_E === 1'b1) begin found = 1'b1; break; end
    end
    chk("mid_e_seen", found, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_e",   bus.LCD_E, 1'b0);
    chk("mid_rst_rdy", bus.RDY, 1'b0);
    chk("mid_rst_db",  bus.LCD_DB, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    observe(1500, 0, 0);
    check_init("rerst", T_POWERUP);
    send("after", 2'b00, 8'h7A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
